div: RTL and testbench

- Multi-cycle 32-bit integer divider; the responder side of the divide handshake driven by the execute stage.
- The execute stage raises start_i with operands and stalls the pipeline on its own side until ready_o.
- It then writes result_o[63:32] (remainder) to HI and result_o[31:0] (quotient) to LO.
- Radix-2 restoring algorithm: one quotient bit per cycle, with signed/unsigned select and an annul path for flushes.

---
 rtl/div.sv | 165 ++++++++++++++++
 tb/tb_div.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) with annul support.
// Optional early-out for |dividend| < |divisor| enabled by DIV_EARLY_OUT_EN.
module div #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(DATA_W);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                signed_q, signed_d;
  logic                sign1_q, sign1_d;
  logic                sign2_q, sign2_d;
  logic [DATA_W-1:0]   dividend_q, dividend_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [2*DATA_W-1:0] result_d;
  logic                ready_d;
`ifdef DIV_EARLY_OUT_EN
  logic                early_q, early_d;
`endif

  logic                op1_neg_c, op2_neg_c;
  logic [DATA_W-1:0]   mag1_c, mag2_c;
  logic [DATA_W:0]     partial_c, diff_c;
  logic [DATA_W-1:0]   quo_fix_c, rem_fix_c;

  // Operand magnitudes at acceptance
  assign op1_neg_c = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg_c = signed_div_i & opdata2_i[DATA_W-1];
  assign mag1_c    = op1_neg_c ? -opdata1_i : opdata1_i;
  assign mag2_c    = op2_neg_c ? -opdata2_i : opdata2_i;

  // One restoring step: dividend_q shifts out MSB-first while quotient bits shift in
  assign partial_c = {rem_q, dividend_q[DATA_W-1]};
  assign diff_c    = partial_c - {1'b0, divisor_q};

  // Sign fix-up: quotient sign is sign1^sign2, remainder follows the dividend
  assign quo_fix_c = (signed_q && (sign1_q ^ sign2_q)) ? -dividend_q : dividend_q;
  assign rem_fix_c = (signed_q && sign1_q) ? -rem_q : rem_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    signed_d   = signed_q;
    sign1_d    = sign1_q;
    sign2_d    = sign2_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    result_d   = result_o;
    ready_d    = ready_o;
`ifdef DIV_EARLY_OUT_EN
    early_d    = early_q;
`endif
    case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          signed_d   = signed_div_i;
          sign1_d    = op1_neg_c;
          sign2_d    = op2_neg_c;
          dividend_d = mag1_c;
          divisor_d  = mag2_c;
          rem_d      = '0;
          cnt_d      = '0;
`ifdef DIV_EARLY_OUT_EN
          early_d    = 1'b0;
          if (opdata2_i == '0) begin
            state_d = BYZERO;
          end else if (mag1_c < mag2_c) begin
            early_d = 1'b1;
            state_d = BYZERO;
          end else begin
            state_d = ON;
          end
`else
          if (opdata2_i == '0) state_d = BYZERO;
          else                 state_d = ON;
`endif
        end
      end
      BYZERO: begin
        // Single-cycle completion: divide-by-zero, or early-out when enabled
        state_d = END;
        ready_d = 1'b1;
`ifdef DIV_EARLY_OUT_EN
        if (early_q) result_d = {(sign1_q ? -dividend_q : dividend_q), {DATA_W{1'b0}}};
        else         result_d = '0;
`else
        result_d = '0;
`endif
      end
      ON: begin
        if (annul_i) begin
          state_d = FREE;
          cnt_d   = '0;
        end else if (cnt_q < ITER_LAST) begin
          rem_d      = diff_c[DATA_W] ? partial_c[DATA_W-1:0] : diff_c[DATA_W-1:0];
          dividend_d = {dividend_q[DATA_W-2:0], ~diff_c[DATA_W]};
          cnt_d      = cnt_q + CNT_W'(1);
        end else begin
          result_d = {rem_fix_c, quo_fix_c};
          ready_d  = 1'b1;
          state_d  = END;
        end
      end
      END: begin
        if (!start_i || annul_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FREE;
      cnt_q      <= '0;
      signed_q   <= 1'b0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      result_o   <= '0;
      ready_o    <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
      early_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      signed_q   <= signed_d;
      sign1_q    <= sign1_d;
      sign2_q    <= sign2_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      result_o   <= result_d;
      ready_o    <= ready_d;
`ifdef DIV_EARLY_OUT_EN
      early_q    <= early_d;
`endif
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the multi-cycle divider.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start an operation and count edges until ready_o; operands are scrambled after acceptance
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b, output int lat);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    lat          = 0;
    do begin
      step();
      lat++;
      if (lat == 1) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
    end while (!ready_o && lat < 100);
  endtask

  task automatic drop_start(input string name);
    start_i = 1'b0;
    step();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++;
      $display("FAIL %s_release: ready=%b result=%h, required ready=0 result=0", name, ready_o, result_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'h0; opdata2_i = 32'h0;
    step(); step();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++;
      $display("FAIL reset: ready=%b result=%h, required 0/0", ready_o, result_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_unsigned();
    int lat;
    run_op(1'b0, 32'd100, 32'd7, lat);
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL udiv_latency: got %0d, required 34", lat); end
    checks++;
    if (result_o !== 64'h00000002_0000000E) begin
      errors++; $display("FAIL udiv_result: got %h, required 000000020000000e", result_o);
    end
    // start_i held in END must neither restart nor disturb the result
    repeat (3) step();
    checks++;
    if (ready_o !== 1'b1 || result_o !== 64'h00000002_0000000E) begin
      errors++; $display("FAIL udiv_hold: ready=%b result=%h, required 1/000000020000000e", ready_o, result_o);
    end
    drop_start("udiv");
  endtask

  task automatic test_signed();
    int lat;
    run_op(1'b1, 32'hFFFFFFF9, 32'h00000002, lat);
    checks++;
    if (lat !== 34 || result_o !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++; $display("FAIL sdiv_neg7_2: lat=%0d result=%h, required 34/fffffffffffffffd", lat, result_o);
    end
    drop_start("sdiv_neg7_2");
    run_op(1'b1, 32'h00000007, 32'hFFFFFFFE, lat);
    checks++;
    if (lat !== 34 || result_o !== 64'h00000001_FFFFFFFD) begin
      errors++; $display("FAIL sdiv_7_neg2: lat=%0d result=%h, required 34/00000001fffffffd", lat, result_o);
    end
    drop_start("sdiv_7_neg2");
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(1'b1, 32'd5, 32'd0, lat);
    checks++;
    if (lat !== 2 || result_o !== 64'h0) begin
      errors++; $display("FAIL divzero_signed: lat=%0d result=%h, required 2/0", lat, result_o);
    end
    drop_start("divzero_signed");
    run_op(1'b0, 32'd5, 32'd0, lat);
    checks++;
    if (lat !== 2 || result_o !== 64'h0) begin
      errors++; $display("FAIL divzero_unsigned: lat=%0d result=%h, required 2/0", lat, result_o);
    end
    drop_start("divzero_unsigned");
  endtask

  task automatic test_annul();
    int lat;
    logic seen;
    seen = 1'b0;
    signed_div_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd1;
    start_i = 1'b1; annul_i = 1'b0;
    repeat (11) begin step(); seen |= ready_o; end
    annul_i = 1'b1; start_i = 1'b0;
    step(); seen |= ready_o;
    annul_i = 1'b0;
    repeat (40) begin step(); seen |= ready_o; end
    checks++;
    if (seen !== 1'b0 || result_o !== 64'h0) begin
      errors++; $display("FAIL annul_no_ready: seen=%b result=%h, required 0/0", seen, result_o);
    end
    run_op(1'b0, 32'd9, 32'd3, lat);
    checks++;
    if (lat !== 34 || result_o !== 64'h00000000_00000003) begin
      errors++; $display("FAIL annul_restart: lat=%0d result=%h, required 34/0000000000000003", lat, result_o);
    end
    drop_start("annul_restart");
  endtask

  task automatic test_overflow();
    int lat;
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat);
    checks++;
    if (lat !== 34 || result_o !== 64'h00000000_80000000) begin
      errors++; $display("FAIL ovf_signed: lat=%0d result=%h, required 34/0000000080000000", lat, result_o);
    end
    drop_start("ovf_signed");
    run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, lat);
    checks++;
    if (lat !== 34 || result_o !== 64'h80000000_00000000) begin
      errors++; $display("FAIL ovf_unsigned: lat=%0d result=%h, required 34/8000000000000000", lat, result_o);
    end
    drop_start("ovf_unsigned");
  endtask

  task automatic test_early_out();
    int lat;
    int exp_lat;
`ifdef DIV_EARLY_OUT_EN
    exp_lat = 2;
`else
    exp_lat = 34;
`endif
    run_op(1'b0, 32'd3, 32'd10, lat);
    checks++;
    if (lat !== exp_lat || result_o !== 64'h00000003_00000000) begin
      errors++; $display("FAIL small_udiv: lat=%0d result=%h, required %0d/0000000300000000", lat, result_o, exp_lat);
    end
    drop_start("small_udiv");
    run_op(1'b1, 32'hFFFFFFFD, 32'd10, lat);
    checks++;
    if (lat !== exp_lat || result_o !== 64'hFFFFFFFD_00000000) begin
      errors++; $display("FAIL small_sdiv: lat=%0d result=%h, required %0d/fffffffd00000000", lat, result_o, exp_lat);
    end
    drop_start("small_sdiv");
  endtask

  task automatic test_reset_mid();
    int lat;
    logic seen;
    seen = 1'b0;
    signed_div_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd1;
    start_i = 1'b1; annul_i = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++; $display("FAIL reset_mid_on: ready=%b result=%h, required 0/0", ready_o, result_o);
    end
    start_i = 1'b0; rst = 1'b0;
    repeat (40) begin step(); seen |= ready_o; end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL reset_mid_no_ready: ready seen=%b, required 0", seen);
    end
    // After reset the counter must start fresh and the result be exact
    run_op(1'b0, 32'd9, 32'd3, lat);
    checks++;
    if (lat !== 34 || result_o !== 64'h00000000_00000003) begin
      errors++; $display("FAIL reset_then_op: lat=%0d result=%h, required 34/0000000000000003", lat, result_o);
    end
    rst = 1'b1;
    step();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++; $display("FAIL reset_in_end: ready=%b result=%h, required 0/0", ready_o, result_o);
    end
    rst = 1'b0; start_i = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_overflow();
    test_early_out();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
